// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard sequencer.
//   - RV32I opcode constants
//   - hz_state_t: hazard sequencer states
//   - rd/rs1/rs2/opcode field-slice helpers
package hazard_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } hz_state_t;

  function automatic logic [6:0] opcode(input logic [31:0] inst);
    return inst[6:0];
  endfunction

  function automatic logic [4:0] rd(input logic [31:0] inst);
    return inst[11:7];
  endfunction

  function automatic logic [4:0] rs1(input logic [31:0] inst);
    return inst[19:15];
  endfunction

  function automatic logic [4:0] rs2(input logic [31:0] inst);
    return inst[24:20];
  endfunction

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// load_use_detect: combinational load-use hazard detector.
// Flags a hazard when the load in EX writes a non-zero rd that the
// instruction in ID actually reads as rs1 or rs2.
// Ports:
//   inst_id  in  32  consumer instruction (ID)
//   inst_ex  in  32  producer instruction (EX)
//   valid_id in  1   inst_id valid
//   valid_ex in  1   inst_ex valid
//   hazard   out 1   load-use hazard present
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [31:0] inst_id,
  input  logic [31:0] inst_ex,
  input  logic        valid_id,
  input  logic        valid_ex,
  output logic        hazard
);

  logic [6:0] op_id;
  logic [6:0] op_ex;
  logic [4:0] ex_rd;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       unused_fields;

  assign op_id = opcode(inst_id);
  assign op_ex = opcode(inst_ex);
  assign ex_rd = rd(inst_ex);

  // Only formats that really read a register field may create a hazard;
  // U/J formats carry immediate bits in those positions.
  assign uses_rs1 = (op_id == OP_R)     || (op_id == OP_I)      ||
                    (op_id == OP_LOAD)  || (op_id == OP_STORE)  ||
                    (op_id == OP_BRANCH)|| (op_id == OP_JALR);
  assign uses_rs2 = (op_id == OP_R) || (op_id == OP_STORE) || (op_id == OP_BRANCH);

  assign hazard = valid_ex && valid_id && (op_ex == OP_LOAD) && (ex_rd != 5'd0) &&
                  ((uses_rs1 && (ex_rd == rs1(inst_id))) ||
                   (uses_rs2 && (ex_rd == rs2(inst_id))));

  assign unused_fields = ^{inst_id[31:25], inst_id[14:7], inst_ex[31:12]};

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard sequencer for the RV32I 5-stage core.
// Inserts load-use bubbles, sequences mispredict flushes and freezes the
// pipe while data memory is busy. Priority: memory wait > mispredict >
// load-use.
// Optional feature macro: HAZARD_PERF_CNT_EN (performance counters;
// when undefined stall_cnt/flush_cnt are tied to 0).
// Ports:
//   clk, rst_n             clock, async active-low reset
//   inst_id/inst_ex        instructions in ID / EX
//   valid_id/valid_ex      instruction valids
//   mispredict             EX resolved a mispredicted branch/JALR
//   dmem_req/dmem_ready    MEM-stage request / completion
//   stall_pc, stall_if_id  hold PC / IF/ID
//   bubble_ex              load NOP into ID/EX
//   flush_if_id/id_ex      clear IF/ID / ID/EX
//   freeze_all             hold every pipeline register
//   stall_cnt, flush_cnt   performance counters (saturating)
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES      = 1,
  parameter int unsigned CNT_W             = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst_id,
  input  logic [31:0]      inst_ex,
  input  logic             valid_id,
  input  logic             valid_ex,
  input  logic             mispredict,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             freeze_all,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] LD_EXTRA = 2'(LOAD_STALL_CYCLES - 1);
  localparam logic [1:0] FL_EXTRA = 2'(FLUSH_CYCLES - 1);

  hz_state_t  state_q, state_d;
  hz_state_t  saved_state_q, saved_state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] saved_cnt_q, saved_cnt_d;
  logic       live_q;
  logic       hazard;
  logic       mem_stall;

  load_use_detect u_load_use_detect (
    .inst_id  (inst_id),
    .inst_ex  (inst_ex),
    .valid_id (valid_id),
    .valid_ex (valid_ex),
    .hazard   (hazard)
  );

  assign mem_stall = dmem_req && !dmem_ready;

  // live_q keeps the block inert (outputs 0, no state change) for the
  // first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q        <= 1'b0;
      state_q       <= RUN;
      cnt_q         <= '0;
      saved_state_q <= RUN;
      saved_cnt_q   <= '0;
    end else begin
      live_q        <= 1'b1;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      saved_state_q <= saved_state_d;
      saved_cnt_q   <= saved_cnt_d;
    end
  end

  // cnt_q holds the remaining extra cycles of LD_STALL or FLUSH; a memory
  // wait parks it together with the interrupted state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    saved_state_d = saved_state_q;
    saved_cnt_d   = saved_cnt_q;
    if (live_q) begin
      if (state_q == MEM_WAIT) begin
        if (dmem_ready) begin
          state_d = saved_state_q;
          cnt_d   = saved_cnt_q;
        end
      end else if (mem_stall) begin
        state_d       = MEM_WAIT;
        saved_state_d = state_q;
        saved_cnt_d   = cnt_q;
      end else if (mispredict) begin
        if (FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          cnt_d   = FL_EXTRA;
        end else begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end else begin
        case (state_q)
          RUN: begin
            if (hazard && (LOAD_STALL_CYCLES > 1)) begin
              state_d = LD_STALL;
              cnt_d   = LD_EXTRA;
            end
          end
          LD_STALL, FLUSH: begin
            if (cnt_q <= 2'd1) begin
              state_d = RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    freeze_all  = 1'b0;
    if (live_q) begin
      if (state_q == MEM_WAIT) begin
        freeze_all = !dmem_ready;
      end else if (mem_stall) begin
        freeze_all = 1'b1;
      end else if (mispredict || (state_q == FLUSH)) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if ((state_q == LD_STALL) || hazard) begin
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        bubble_ex   = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             stall_evt;
  logic             flush_evt;

  assign stall_evt = stall_pc || freeze_all;
  // A flush output together with mispredict marks a new flush event;
  // flush without mispredict is the tail of an earlier one.
  assign flush_evt = flush_if_id && mispredict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_evt && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst_id, inst_ex;
  logic        valid_id, valid_ex, mispredict, dmem_req, dmem_ready;

  logic        a_spc, a_sif, a_bub, a_fif, a_fex, a_frz;
  logic        b_spc, b_sif, b_bub, b_fif, b_fex, b_frz;
  logic [31:0] a_scnt, a_fcnt;
  logic [2:0]  b_scnt, b_fcnt;
  logic [5:0]  o1, o3;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [5:0] NONE  = 6'b000000;
  localparam logic [5:0] STALL = 6'b111000;
  localparam logic [5:0] FLSH  = 6'b000110;
  localparam logic [5:0] FRZ   = 6'b000001;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .inst_id(inst_id), .inst_ex(inst_ex),
    .valid_id(valid_id), .valid_ex(valid_ex), .mispredict(mispredict),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall_pc(a_spc), .stall_if_id(a_sif), .bubble_ex(a_bub),
    .flush_if_id(a_fif), .flush_id_ex(a_fex), .freeze_all(a_frz),
    .stall_cnt(a_scnt), .flush_cnt(a_fcnt));

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .inst_id(inst_id), .inst_ex(inst_ex),
    .valid_id(valid_id), .valid_ex(valid_ex), .mispredict(mispredict),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall_pc(b_spc), .stall_if_id(b_sif), .bubble_ex(b_bub),
    .flush_if_id(b_fif), .flush_id_ex(b_fex), .freeze_all(b_frz),
    .stall_cnt(b_scnt), .flush_cnt(b_fcnt));

  assign o1 = {a_spc, a_sif, a_bub, a_fif, a_fex, a_frz};
  assign o3 = {b_spc, b_sif, b_bub, b_fif, b_fex, b_frz};

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b010, rd, op};
  endfunction

  function automatic int ec(input int n);
    return PERF ? n : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i_id, input logic [31:0] i_ex, input logic vi,
                       input logic ve, input logic mp, input logic rq, input logic rdy);
    inst_id = i_id; inst_ex = i_ex; valid_id = vi; valid_ex = ve;
    mispredict = mp; dmem_req = rq; dmem_ready = rdy;
  endtask

  task automatic step(input logic [31:0] i_id, input logic [31:0] i_ex, input logic vi,
                      input logic ve, input logic mp, input logic rq, input logic rdy);
    @(negedge clk);
    drive(i_id, i_ex, vi, ve, mp, rq, rdy);
    #1;
  endtask

  task automatic idle();
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [31:0] LW5, LW0, ADD_657, ADD_607, ADD_675, ADDI_675, SW_25, BEQ_59,
               JALR_5, LUI_X, JAL_X, ADDI_X5, ADD_689;

  // Release checks: outputs zero with hazard inputs present both in reset
  // and in the first cycle after release.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(ADD_657, LW5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    chk("rst_out1", 32'(o1), 32'(NONE));
    chk("rst_out3", 32'(o3), 32'(NONE));
    chk("rst_scnt1", a_scnt, 0);
    chk("rst_fcnt1", a_fcnt, 0);
    chk("rst_scnt3", 32'(b_scnt), 0);
    rst_n = 1'b1;
    drive(ADD_657, LW5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rel_out1", 32'(o1), 32'(NONE));
    chk("rel_out3", 32'(o3), 32'(NONE));
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [31:0] id;
    logic [31:0] ex;
    logic        vid;
    logic        vex;
    logic        misp;
    logic [5:0]  exp;
  } vec_t;

  vec_t vecs[15];

  initial begin
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    LW5      = enc(7'b0000011, 5'd5, 5'd1, 5'd0);
    LW0      = enc(7'b0000011, 5'd0, 5'd1, 5'd0);
    ADD_657  = enc(7'b0110011, 5'd6, 5'd5, 5'd7);
    ADD_607  = enc(7'b0110011, 5'd6, 5'd0, 5'd7);
    ADD_675  = enc(7'b0110011, 5'd6, 5'd7, 5'd5);
    ADDI_675 = enc(7'b0010011, 5'd6, 5'd7, 5'd5);
    SW_25    = enc(7'b0100011, 5'd0, 5'd2, 5'd5);
    BEQ_59   = enc(7'b1100011, 5'd0, 5'd5, 5'd9);
    JALR_5   = enc(7'b1100111, 5'd1, 5'd5, 5'd0);
    LUI_X    = enc(7'b0110111, 5'd6, 5'd5, 5'd5);
    JAL_X    = enc(7'b1101111, 5'd5, 5'd5, 5'd5);
    ADDI_X5  = enc(7'b0010011, 5'd5, 5'd1, 5'd0);
    ADD_689  = enc(7'b0110011, 5'd6, 5'd8, 5'd9);

    vecs[0]  = '{ADD_657,  LW5,     1, 1, 0, STALL};
    vecs[1]  = '{ADD_607,  LW0,     1, 1, 0, NONE};
    vecs[2]  = '{ADDI_675, LW5,     1, 1, 0, NONE};
    vecs[3]  = '{ADD_675,  LW5,     1, 1, 0, STALL};
    vecs[4]  = '{SW_25,    LW5,     1, 1, 0, STALL};
    vecs[5]  = '{BEQ_59,   LW5,     1, 1, 0, STALL};
    vecs[6]  = '{JALR_5,   LW5,     1, 1, 0, STALL};
    vecs[7]  = '{LUI_X,    LW5,     1, 1, 0, NONE};
    vecs[8]  = '{JAL_X,    LW5,     1, 1, 0, NONE};
    vecs[9]  = '{ADD_657,  LW5,     0, 1, 0, NONE};
    vecs[10] = '{ADD_657,  LW5,     1, 0, 0, NONE};
    vecs[11] = '{ADD_657,  ADDI_X5, 1, 1, 0, NONE};
    vecs[12] = '{ADD_689,  LW5,     1, 1, 0, NONE};
    vecs[13] = '{ADD_657,  LW5,     1, 1, 1, FLSH};
    vecs[14] = '{ADDI_675, LW5,     1, 1, 1, FLSH};

    // Table: single-cycle behaviour of the 1/1 instance
    do_reset();
    begin
      int n_st = 0;
      int n_fl = 0;
      for (int unsigned i = 0; i < 15; i++) begin
        step(vecs[i].id, vecs[i].ex, vecs[i].vid, vecs[i].vex, vecs[i].misp, 1'b0, 1'b0);
        chk($sformatf("vec%0d", i), 32'(o1), 32'(vecs[i].exp));
        if (vecs[i].exp == STALL) n_st++;
        if (vecs[i].exp == FLSH) n_fl++;
      end
      idle();
      chk("vec_scnt", a_scnt, ec(n_st));
      chk("vec_fcnt", a_fcnt, ec(n_fl));
    end

    // Load-use stall length: 1 cycle vs 3 cycles
    do_reset();
    step(ADD_657, LW5, 1, 1, 0, 0, 0);
    chk("lu_c1_d1", 32'(o1), 32'(STALL));
    chk("lu_c1_d3", 32'(o3), 32'(STALL));
    idle();
    chk("lu_c2_d1", 32'(o1), 32'(NONE));
    chk("lu_c2_d3", 32'(o3), 32'(STALL));
    chk("lu_scnt1", a_scnt, ec(1));
    idle();
    chk("lu_c3_d3", 32'(o3), 32'(STALL));
    idle();
    chk("lu_c4_d3", 32'(o3), 32'(NONE));
    chk("lu_scnt3", 32'(b_scnt), ec(3));

    // Mispredict with load-use, then restart during FLUSH
    do_reset();
    step(ADD_657, LW5, 1, 1, 1, 0, 0);
    chk("mp_c1_d1", 32'(o1), 32'(FLSH));
    chk("mp_c1_d3", 32'(o3), 32'(FLSH));
    idle();
    chk("mp_c2_d1", 32'(o1), 32'(NONE));
    chk("mp_c2_d3", 32'(o3), 32'(FLSH));
    chk("mp_fcnt1", a_fcnt, ec(1));
    chk("mp_fcnt3", 32'(b_fcnt), ec(1));
    idle();
    chk("mp_c3_d3", 32'(o3), 32'(NONE));
    step(32'h0, 32'h0, 0, 0, 1, 0, 0);
    chk("mp_c4_d3", 32'(o3), 32'(FLSH));
    step(32'h0, 32'h0, 0, 0, 1, 0, 0);
    chk("mp_c5_d3", 32'(o3), 32'(FLSH));
    idle();
    chk("mp_c6_d3", 32'(o3), 32'(FLSH));
    idle();
    chk("mp_c7_d3", 32'(o3), 32'(NONE));
    chk("mp_fcnt1b", a_fcnt, ec(3));
    chk("mp_fcnt3b", 32'(b_fcnt), ec(3));

    // Memory wait of 4 cycles, mispredict ignored meanwhile
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(32'h0, 32'h0, 0, 0, 1, 1, 0);
      chk($sformatf("mw%0d_d1", k), 32'(o1), 32'(FRZ));
      chk($sformatf("mw%0d_d3", k), 32'(o3), 32'(FRZ));
    end
    step(32'h0, 32'h0, 0, 0, 0, 1, 1);
    chk("mw_rdy_d1", 32'(o1), 32'(NONE));
    chk("mw_rdy_d3", 32'(o3), 32'(NONE));
    idle();
    chk("mw_after_d1", 32'(o1), 32'(NONE));
    chk("mw_scnt1", a_scnt, ec(4));
    chk("mw_scnt3", 32'(b_scnt), ec(4));
    chk("mw_fcnt1", a_fcnt, 0);

    // Memory wait interrupting LD_STALL resumes the remaining stall cycles
    do_reset();
    step(ADD_657, LW5, 1, 1, 0, 0, 0);
    chk("ml_c1_d3", 32'(o3), 32'(STALL));
    step(32'h0, 32'h0, 0, 0, 0, 1, 0);
    chk("ml_c2_d3", 32'(o3), 32'(FRZ));
    step(32'h0, 32'h0, 0, 0, 0, 1, 0);
    chk("ml_c3_d3", 32'(o3), 32'(FRZ));
    step(32'h0, 32'h0, 0, 0, 0, 1, 1);
    chk("ml_c4_d3", 32'(o3), 32'(NONE));
    idle();
    chk("ml_c5_d3", 32'(o3), 32'(STALL));
    chk("ml_c5_d1", 32'(o1), 32'(NONE));
    idle();
    chk("ml_c6_d3", 32'(o3), 32'(STALL));
    idle();
    chk("ml_c7_d3", 32'(o3), 32'(NONE));
    chk("ml_scnt3", 32'(b_scnt), ec(5));
    chk("ml_scnt1", a_scnt, ec(3));

    // Reset asserted in the middle of LD_STALL
    do_reset();
    step(ADD_657, LW5, 1, 1, 0, 0, 0);
    idle();
    chk("ra_ld_d3", 32'(o3), 32'(STALL));
    rst_n = 1'b0;
    #1;
    chk("ra_now_d3", 32'(o3), 32'(NONE));
    chk("ra_scnt3", 32'(b_scnt), 0);
    do_reset();
    idle();
    chk("ra_first_d3", 32'(o3), 32'(NONE));
    step(ADD_657, LW5, 1, 1, 0, 0, 0);
    chk("ra_run_d3", 32'(o3), 32'(STALL));
    idle();
    chk("ra_run2_d1", 32'(o1), 32'(NONE));

    // Counter saturation (3-bit counter on the second instance)
    do_reset();
    for (int k = 0; k < 10; k++) step(32'h0, 32'h0, 0, 0, 0, 1, 0);
    step(32'h0, 32'h0, 0, 0, 0, 1, 1);
    idle();
    chk("sat_scnt3", 32'(b_scnt), ec(7));
    chk("sat_scnt1", a_scnt, ec(10));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
